// File: rtl/step_pulse_gen.sv
// Step pulse generator: while start is held, emits N evenly spaced pulses per
// second (N chosen by the mode latched at RUN entry), then idles for the remainder.
module step_pulse_gen #(
  parameter int CLK_HZ = 100000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] mode,
  output logic       pulseOut,
  output logic       active,
  output logic [3:0] sec_index,
  output logic [7:0] rate
);

  localparam int CNT_W = $clog2(CLK_HZ);
  localparam logic [CNT_W-1:0] SEC_LAST = CNT_W'(CLK_HZ - 1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  // Steps scheduled for a second, given the latched mode and second index.
  function automatic logic [7:0] steps_for(input logic [1:0] m, input logic [3:0] idx);
    logic [7:0] n;
    case (m)
      2'b00:   n = 8'd32;
      2'b01:   n = 8'd64;
      2'b10:   n = 8'd128;
      default: begin
        case (idx)
          4'd0:    n = 8'd20;
          4'd1:    n = 8'd33;
          4'd2:    n = 8'd66;
          4'd3:    n = 8'd27;
          4'd4:    n = 8'd70;
          4'd5:    n = 8'd30;
          4'd6:    n = 8'd19;
          4'd7:    n = 8'd30;
          4'd8:    n = 8'd33;
          default: n = 8'd69;
        endcase
      end
    endcase
    return n;
  endfunction

  // N only takes a fixed set of values, so every period is an elaboration-time
  // constant and no runtime divider is needed.
  function automatic logic [CNT_W-1:0] period_for(input logic [7:0] n);
    logic [CNT_W-1:0] p;
    case (n)
      8'd19:   p = CNT_W'(CLK_HZ / 19);
      8'd20:   p = CNT_W'(CLK_HZ / 20);
      8'd27:   p = CNT_W'(CLK_HZ / 27);
      8'd30:   p = CNT_W'(CLK_HZ / 30);
      8'd32:   p = CNT_W'(CLK_HZ / 32);
      8'd33:   p = CNT_W'(CLK_HZ / 33);
      8'd64:   p = CNT_W'(CLK_HZ / 64);
      8'd66:   p = CNT_W'(CLK_HZ / 66);
      8'd69:   p = CNT_W'(CLK_HZ / 69);
      8'd70:   p = CNT_W'(CLK_HZ / 70);
      default: p = CNT_W'(CLK_HZ / 128);
    endcase
    return p;
  endfunction

  state_t           r_state;
  logic [1:0]       r_mode;
  logic [CNT_W-1:0] r_sec_cnt;
  logic [CNT_W-1:0] r_per_cnt;
  logic [8:0]       r_emitted;
  logic [3:0]       r_sec_index;
  logic [7:0]       r_rate;
  logic [CNT_W-1:0] r_period;
  logic             r_pulse;

  state_t           w_state_next;
  logic [1:0]       w_mode_next;
  logic [CNT_W-1:0] w_sec_cnt_next;
  logic [CNT_W-1:0] w_per_cnt_next;
  logic [8:0]       w_emitted_next;
  logic [3:0]       w_sec_index_next;
  logic [7:0]       w_rate_next;
  logic [CNT_W-1:0] w_period_next;
  logic             w_pulse_next;

  logic [CNT_W-1:0] w_high;
  logic [3:0]       w_sec_index_inc;
  logic [7:0]       w_entry_rate;
  logic [CNT_W-1:0] w_entry_period;
  logic [7:0]       w_wrap_rate;
  logic [CNT_W-1:0] w_wrap_period;

  assign w_high          = r_period >> 1;
  assign w_sec_index_inc = (r_sec_index == 4'd15) ? 4'd15 : r_sec_index + 4'd1;
  assign w_entry_rate    = steps_for(mode, 4'd0);
  assign w_entry_period  = period_for(w_entry_rate);
  assign w_wrap_rate     = steps_for(r_mode, w_sec_index_inc);
  assign w_wrap_period   = period_for(w_wrap_rate);

  always_comb begin
    w_state_next     = r_state;
    w_mode_next      = r_mode;
    w_sec_cnt_next   = r_sec_cnt;
    w_per_cnt_next   = r_per_cnt;
    w_emitted_next   = r_emitted;
    w_sec_index_next = r_sec_index;
    w_rate_next      = r_rate;
    w_period_next    = r_period;
    w_pulse_next     = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next     = S_RUN;
          w_mode_next      = mode;
          w_sec_cnt_next   = '0;
          w_per_cnt_next   = '0;
          w_emitted_next   = '0;
          w_sec_index_next = '0;
          w_rate_next      = w_entry_rate;
          w_period_next    = w_entry_period;
          w_pulse_next     = 1'b1;
        end
      end

      default: begin
        if (!start) begin
          w_state_next     = S_IDLE;
          w_sec_cnt_next   = '0;
          w_per_cnt_next   = '0;
          w_emitted_next   = '0;
          w_sec_index_next = '0;
          w_rate_next      = '0;
          w_period_next    = '0;
        end else if (r_sec_cnt == SEC_LAST) begin
          // Second boundary wins over the period counter so no pulse spans it.
          w_sec_cnt_next   = '0;
          w_per_cnt_next   = '0;
          w_emitted_next   = '0;
          w_sec_index_next = w_sec_index_inc;
          w_rate_next      = w_wrap_rate;
          w_period_next    = w_wrap_period;
          w_pulse_next     = 1'b1;
        end else begin
          w_sec_cnt_next = r_sec_cnt + CNT_W'(1);
          if (r_per_cnt == r_period - CNT_W'(1)) begin
            w_per_cnt_next = '0;
            if (r_emitted != '1) begin
              w_emitted_next = r_emitted + 9'd1;
            end
          end else begin
            w_per_cnt_next = r_per_cnt + CNT_W'(1);
          end
          w_pulse_next = (w_per_cnt_next < w_high) && (w_emitted_next < {1'b0, r_rate});
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_mode      <= 2'b00;
      r_sec_cnt   <= '0;
      r_per_cnt   <= '0;
      r_emitted   <= '0;
      r_sec_index <= '0;
      r_rate      <= '0;
      r_period    <= '0;
      r_pulse     <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_mode      <= w_mode_next;
      r_sec_cnt   <= w_sec_cnt_next;
      r_per_cnt   <= w_per_cnt_next;
      r_emitted   <= w_emitted_next;
      r_sec_index <= w_sec_index_next;
      r_rate      <= w_rate_next;
      r_period    <= w_period_next;
      r_pulse     <= w_pulse_next;
    end
  end

  assign pulseOut  = r_pulse;
  assign active    = (r_state == S_RUN);
  assign sec_index = r_sec_index;
  assign rate      = r_rate;

endmodule

// File: tb/tb_step_pulse_gen.sv
// Bench for step_pulse_gen: a time-since-entry model checked every cycle, plus
// directed scenarios with hand-computed pulse counts per second.
module tb_step_pulse_gen;

  localparam int C = 1280;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [1:0] mode;
  logic       pulse;
  logic       active;
  logic [3:0] sec_index;
  logic [7:0] rate;

  always #5 clk = ~clk;

  step_pulse_gen #(.CLK_HZ(C)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .mode      (mode),
    .pulseOut  (pulse),
    .active    (active),
    .sec_index (sec_index),
    .rate      (rate)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  // Model: RUN is described only by t, the cycle count since RUN entry.
  function automatic int model_n(input logic [1:0] m, input int s);
    case (m)
      2'b00: return 32;
      2'b01: return 64;
      2'b10: return 128;
      default: begin
        case (s)
          0: return 20;
          1: return 33;
          2: return 66;
          3: return 27;
          4: return 70;
          5: return 30;
          6: return 19;
          7: return 30;
          8: return 33;
          default: return 69;
        endcase
      end
    endcase
  endfunction

  function automatic int model_pulse(input int t, input logic [1:0] m);
    int n, p, o;
    n = model_n(m, t / C);
    p = C / n;
    o = t % C;
    return ((o / p) < n && (o % p) < (p / 2)) ? 1 : 0;
  endfunction

  bit         m_run = 1'b0;
  int         m_t = 0;
  logic [1:0] m_mode = 2'b00;
  int         cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) m_run <= 1'b0;
    else if (!m_run) begin
      if (start) begin
        m_run  <= 1'b1;
        m_t    <= 0;
        m_mode <= mode;
      end
    end else if (!start) m_run <= 1'b0;
    else m_t <= m_t + 1;
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      if (m_run) begin
        chk("model_pulseOut", int'(pulse), model_pulse(m_t, m_mode));
        chk("model_active", int'(active), 1);
        chk("model_sec_index", int'(sec_index), (m_t / C > 15) ? 15 : m_t / C);
        chk("model_rate", int'(rate), model_n(m_mode, m_t / C));
      end else begin
        chk("model_idle_pulseOut", int'(pulse), 0);
        chk("model_idle_active", int'(active), 0);
        chk("model_idle_sec_index", int'(sec_index), 0);
        chk("model_idle_rate", int'(rate), 0);
      end
    end
  end

  // Free-running observers; the stimulus takes differences over windows.
  logic prev_p = 1'b0;
  int   edge_cnt = 0;
  int   hi_cnt = 0;
  int   low_run = 0;

  always @(negedge clk) begin
    if (pulse === 1'b1 && prev_p === 1'b0) edge_cnt <= edge_cnt + 1;
    hi_cnt  <= hi_cnt + ((pulse === 1'b1) ? 1 : 0);
    low_run <= (pulse === 1'b1) ? 0 : low_run + 1;
    prev_p  <= pulse;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  int hyb_exp[11] = '{20, 33, 66, 27, 70, 30, 19, 30, 33, 69, 69};
  int e0;
  int h0;

  initial begin
    reset = 1'b1;
    start = 1'b1;
    mode  = 2'b00;
    tick(3);
    chk("reset_pulseOut", int'(pulse), 0);
    chk("reset_active", int'(active), 0);
    chk("reset_rate", int'(rate), 0);
    chk("reset_sec_index", int'(sec_index), 0);
    $display("reset with start high: outputs held at 0");

    // walk: start one cycle after reset release
    reset = 1'b0;
    start = 1'b0;
    tick(1);
    start = 1'b1;
    e0 = edge_cnt;
    h0 = hi_cnt;
    tick(1);
    chk("walk_first_rise", int'(pulse), 1);
    chk("walk_rate", int'(rate), 32);
    chk("walk_active", int'(active), 1);
    tick(C - 1);
    chk("walk_edges_s0", edge_cnt - e0, 32);
    chk("walk_high_s0", hi_cnt - h0, 32 * 20);
    e0 = edge_cnt;
    tick(C);
    chk("walk_edges_s1", edge_cnt - e0, 32);
    chk("walk_sec_index_s1", int'(sec_index), 1);
    $display("walk: 2 seconds, 32 edges each");

    // run: P=10, 5 high, no leftover
    start = 1'b0;
    tick(1);
    mode  = 2'b10;
    start = 1'b1;
    e0 = edge_cnt;
    h0 = hi_cnt;
    tick(C);
    chk("run_edges_s0", edge_cnt - e0, 128);
    chk("run_high_s0", hi_cnt - h0, 128 * 5);
    chk("run_sec_index_s0", int'(sec_index), 0);
    e0 = edge_cnt;
    tick(C);
    chk("run_edges_s1", edge_cnt - e0, 128);
    tick(1);
    chk("run_sec_index_s2", int'(sec_index), 2);
    $display("run: 128 edges per second, sec_index stepping");

    // mode change during RUN is ignored until restart
    start = 1'b0;
    tick(1);
    mode  = 2'b00;
    start = 1'b1;
    e0 = edge_cnt;
    tick(300);
    mode = 2'b10;
    tick(C - 300);
    chk("switch_edges_s0", edge_cnt - e0, 32);
    e0 = edge_cnt;
    tick(C);
    chk("switch_edges_s1", edge_cnt - e0, 32);
    chk("switch_rate_held", int'(rate), 32);
    start = 1'b0;
    tick(1);
    start = 1'b1;
    e0 = edge_cnt;
    tick(C);
    chk("switch_edges_restart", edge_cnt - e0, 128);
    chk("switch_rate_restart", int'(rate), 128);
    $display("mode switch: held at 32 until restart, then 128");

    // jog: drop start in the 5th cycle of a pulse in second 1
    start = 1'b0;
    tick(1);
    mode  = 2'b01;
    start = 1'b1;
    tick(C + 5);
    chk("jog_mid_pulse", int'(pulse), 1);
    chk("jog_sec_index", int'(sec_index), 1);
    start = 1'b0;
    tick(1);
    chk("jog_drop_pulseOut", int'(pulse), 0);
    chk("jog_drop_active", int'(active), 0);
    chk("jog_drop_rate", int'(rate), 0);
    chk("jog_drop_sec_index", int'(sec_index), 0);
    $display("jog: start dropped mid-pulse, pulse truncated");

    // hybrid: 11 seconds of scheduled counts
    mode  = 2'b11;
    start = 1'b1;
    for (int s = 0; s < 11; s++) begin
      e0 = edge_cnt;
      tick(C);
      chk($sformatf("hybrid_edges_s%0d", s), edge_cnt - e0, hyb_exp[s]);
      // second 1: N=33, P=38, H=19 -> 19 low in last period + 26 leftover
      if (s == 1) chk("hybrid_tail_low_s1", low_run, 19 + 26);
      $display("hybrid second %0d: %0d edges", s, edge_cnt - e0);
    end

    // reset mid-RUN with start held, then re-entry
    tick(1);
    chk("hyb_s11_pulse", int'(pulse), 1);
    chk("hyb_s11_sec_index", int'(sec_index), 11);
    reset = 1'b1;
    mode  = 2'b00;
    tick(1);
    chk("rst_mid_pulseOut", int'(pulse), 0);
    chk("rst_mid_active", int'(active), 0);
    chk("rst_mid_sec_index", int'(sec_index), 0);
    chk("rst_mid_rate", int'(rate), 0);
    reset = 1'b0;
    tick(1);
    chk("rst_reentry_pulse", int'(pulse), 1);
    chk("rst_reentry_active", int'(active), 1);
    chk("rst_reentry_sec_index", int'(sec_index), 0);
    chk("rst_reentry_rate", int'(rate), 32);
    $display("reset mid-run: cleared, RUN re-entered in walk");

    start = 1'b0;
    tick(2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
